// File: rtl/xorshift_gen_if.sv
// Seed / word-stream bundle between a seeding master and the xorshift generator.
// master drives seed and backpressure; slave drives the word stream and busy.
interface xorshift_gen_if;
  logic        seed_valid;
  logic [31:0] seed;
  logic        fifo_full;
  logic        out_valid;
  logic [31:0] rand_num;
  logic        busy;

  modport master (
    output seed_valid, seed, fifo_full,
    input  out_valid, rand_num, busy
  );

  modport slave (
    input  seed_valid, seed, fifo_full,
    output out_valid, rand_num, busy
  );
endinterface

// File: rtl/xorshift_gen.sv
// xorshift32 burst generator: 256 words per accepted seed, stalls on fifo_full.
// Define XS_ZERO_GUARD_EN to load a zero seed as 32'h1.
module xorshift_gen (
  input  logic          clk2,
  input  logic          rst_n,
  xorshift_gen_if.slave bus
);

  typedef enum logic {IDLE, GEN} state_e;

  state_e      state_q, state_d;
  logic [31:0] x_q, x_d;
  logic [31:0] rnd_q, rnd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ov_q, ov_d;
  logic        busy_q, busy_d;
  logic [31:0] seed_ld;
  logic [31:0] x_nxt;

  function automatic logic [31:0] xs(input logic [31:0] v);
    logic [31:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

`ifdef XS_ZERO_GUARD_EN
  assign seed_ld = (bus.seed == 32'h0) ? 32'h1 : bus.seed;
`else
  assign seed_ld = bus.seed;
`endif

  assign x_nxt = xs(x_q);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    ov_d    = 1'b0;
    rnd_d   = 32'h0;
    unique case (1'b1)
      (state_q == IDLE) && bus.seed_valid: begin
        x_d     = seed_ld;
        cnt_d   = 8'd0;
        state_d = GEN;
        busy_d  = 1'b1;
      end
      (state_q == GEN) && !bus.fifo_full: begin
        ov_d  = 1'b1;
        rnd_d = x_nxt;
        x_d   = x_nxt;
        cnt_d = cnt_q + 8'd1;
        // last word of the burst: cnt wraps as we drop back to IDLE
        if (cnt_q == 8'd255) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= 32'h0;
      cnt_q   <= 8'd0;
      ov_q    <= 1'b0;
      rnd_q   <= 32'h0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      rnd_q   <= rnd_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.rand_num  = rnd_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/xorshift_gen.md
XORSHIFT_GEN -- requirements
Module: xorshift_gen

Interface
REQ-001 The block SHALL have these ports:
- clk2  input  1  generator clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seed_valid  input  1  one-cycle pulse, seed already synchronised into clk2.
- seed  input  32  initial xorshift state, sampled with seed_valid.
- fifo_full  input  1  downstream CDC FIFO (clk2->clk3) cannot accept a word.
- out_valid  output  1  write strobe to the downstream FIFO, one word per high cycle.
- rand_num  output  32  random word, valid only when out_valid=1.
- busy  output  1  high from seed acceptance until the 256th word is written.

Function
REQ-002 The block SHALL use xorshift32 as its step function xs(x): x^=x<<13; x^=x>>17; x^=x<<5. All widths are 32-bit and bits shifted out are discarded.
REQ-003 The block SHALL have two states, IDLE and GEN, plus a 32-bit state register x and an 8-bit word counter cnt.
REQ-004 In IDLE, at an edge with seed_valid=1, the block SHALL load x<=seed and cnt<=0, enter GEN, and set busy<=1.
REQ-005 In IDLE with seed_valid=0, all registers SHALL hold and out_valid SHALL be 0.
REQ-006 In GEN, at an edge with fifo_full=0, the block SHALL register out_valid<=1, rand_num<=xs(x), x<=xs(x), cnt<=cnt+1.
REQ-007 In GEN, at an edge with fifo_full=1, the block SHALL register out_valid<=0 and hold x and cnt; no word is lost or duplicated.
REQ-008 Whenever out_valid is registered 0, rand_num SHALL be registered to 32'h0.
REQ-009 The block SHALL emit exactly 256 words per seed. When the word with cnt=255 is emitted, cnt wraps to 0, the state returns to IDLE and busy<=0 on that same edge.
REQ-010 Latency: seed_valid sampled at edge k; first out_valid=1 is visible after edge k+1 when fifo_full=0 at k+1.
REQ-011 seed_valid asserted while in GEN, including on the final-word edge, SHALL be ignored, with no effect on x, cnt or the output stream.
REQ-012 A back-to-back seed is accepted no earlier than the edge after busy falls.
REQ-013 fifo_full toggling every cycle SHALL yield out_valid only on edges where fifo_full=0, with a gapless xs sequence.

Reset
REQ-014 rst_n=0 SHALL asynchronously clear out_valid=0, rand_num=0, busy=0, x=0, cnt=0 and state=IDLE.
REQ-015 Reset mid-GEN SHALL abort the run. After release the block waits in IDLE for a new seed_valid and resumes no partial sequence.
REQ-016 Outputs SHALL read 0 immediately after reset, before any clock edge.

Configuration
REQ-017 The macro XS_ZERO_GUARD_EN SHALL control zero-seed handling.
- Defined: a seed of 32'h0 is loaded as 32'h00000001, so output is never stuck at 0.
- Undefined: a seed of 0 is loaded as-is and the block emits 256 words of 32'h0 with normal handshake timing.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset with no clock edge -> out_valid=0, rand_num=0, busy=0.
- seed=32'h1 pulse, fifo_full=0 -> first rand_num=32'h00042021 one edge after acceptance; 256 consecutive out_valid cycles; busy falls with the 256th word; each word matches a reference xs model.
- seed=32'h1, fifo_full=1 for 5 cycles after the 3rd word -> out_valid=0 and rand_num=0 for those cycles; the 4th word equals xs applied four times to 1; total of 256 words still holds.
- Second seed_valid (seed=32'h5) during GEN and on the final-word edge -> ignored; stream continues from seed 1; a seed_valid one edge after busy falls is accepted.
- seed=32'h0 -> with XS_ZERO_GUARD_EN, first word 32'h00042021; without it, 256 words of 32'h0.
- rst_n low after the 100th word -> outputs cleared at once; after release no out_valid until a new seed; a new seed=32'h1 restarts from 32'h00042021.
